comparator_search_controller: RTL and testbench
===============================================

// Module: comparator_search_controller
// PURPOSE
//  Initiator side of the 8-bit magnitude comparator interface. Drives trial operands
//  onto the comparator's second input, reads its gt/eq/lt flags back, and binary-searches
//  the value held on the comparator's first input. Result is the matched value, or a
//  not-found flag. Sits beside the comparator in the special-purpose processor datapath.
// PARAMETERS
//  WIDTH      8   operand width; search range is 0 .. 2**WIDTH-1
//  CNT_W      $clog2(WIDTH+2)   probe counter width; localparam, derived from WIDTH
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      begin a search; sampled only in IDLE
//  guess        out  WIDTH  trial operand to comparator input_2, registered
//  cmp_gt       in   1      comparator output_1: target > guess
//  cmp_eq       in   1      comparator output_2: target == guess
//  cmp_lt       in   1      comparator output_3: target < guess
//  busy         out  1      high in PROBE
//  done         out  1      one-cycle pulse when a search terminates
//  found        out  1      valid with/after done: 1 = match, 0 = exhausted or error
//  result       out  WIDTH  matched value; 0 when not found; held until next start
//  probe_count  out  CNT_W  probes used by the last search; held until next start
// BEHAVIOUR
//  - Reset: state=IDLE; guess, result, probe_count=0; busy, done, found=0. Reset is
//    asynchronous and may arrive mid-search: search is abandoned, no done pulse.
//  - IDLE: when start=1, set lo=0, hi=2**WIDTH-1, guess=(lo+hi)>>1, probe_count=0 and
//    clear found/result. Go to PROBE. start while busy is ignored.
//  - PROBE: flags are combinational from the registered guess; one probe per cycle.
//    Each edge in PROBE increments probe_count, then:
//      eq         -> result=guess, found=1, done=1, go to IDLE
//      gt         -> lo=guess+1. If guess==2**WIDTH-1: found=0, done=1, go to IDLE
//      lt         -> hi=guess-1. If guess==0: found=0, done=1, go to IDLE
//      otherwise, if lo>hi after the update: found=0, done=1, go to IDLE
//      else next guess=(lo+hi)>>1
//  - Midpoint arithmetic: the sum is WIDTH+1 bits wide, so it does not overflow.
//    lo and hi never wrap; both boundaries above are checked before the update.
//  - Latency: start -> done = 1 + probes cycles. Maximum probes = WIDTH+1
//    (9 for WIDTH=8). done is high exactly one cycle; busy drops on that same edge.
//  - start asserted in the done cycle (state already IDLE) starts a new search at once.
// CONFIGURATION
//  CMP_ONEHOT_CHECK_EN defined: in PROBE, if {gt,eq,lt} is not one-hot, the search
//    ends with found=0, done=1, result=0. This check has priority over eq/gt/lt.
//  Not defined: no check. Priority is eq > gt > lt; all-zero flags are treated as lt.
// STRUCTURE
//  comparator_search_pkg: state enum {IDLE, PROBE}, default WIDTH, and CNT_W function.
//  Sub-module search_midpoint (combinational): lo, hi -> (lo+hi)>>1 and the lo>hi
//    exhausted flag. All state and registers stay in the top module.
// TESTING (bench pairs this DUT with the real comparator; target drives input_1)
//  target=100, start -> guesses 127,63,95,111,103,99,101,100; done at cycle 9;
//    found=1, result=100, probe_count=8
//  target=255 -> 9 probes ending 254,255; found=1, result=255, probe_count=9
//  target=0 -> guesses 127,63,31,15,7,3,1,0; found=1, result=0, probe_count=8
//  stub responder always lt -> after guess 0: found=0, result=0, probe_count=8;
//    no underflow, single done pulse
//  rst_n low for 1 cycle during probe 4 -> all outputs zero immediately, no done;
//    a new start then completes normally. start pulses while busy have no effect.
//  CMP_ONEHOT_CHECK_EN, stub drives gt=eq=1 on probe 2 -> done, found=0, probe_count=2;
//    without the macro, the same stimulus -> found=1, result=63

Source files
------------

// File: rtl/comparator_search_controller_pkg.sv
// Shared types and sizing for the comparator search controller.
// Combinational only; no flow control.
// Not applicable: no datapath registers or handshake live here.
package comparator_search_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_e;

    // A search uses at most WIDTH+1 probes, so the counter must hold WIDTH+1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/comparator_search_controller_if.sv
// Bundle of search control, comparator probe and result signals.
// Wires only; no latency.
// No backpressure: start is a level sampled only while the controller is idle.
interface comparator_search_controller_if
    import comparator_search_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();
    localparam int CNT_W = cnt_w(WIDTH);

    logic             start;
    logic [WIDTH-1:0] guess;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             cmp_lt;
    logic             busy;
    logic             done;
    logic             found;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] probe_count;

    modport master (
        input  start, cmp_gt, cmp_eq, cmp_lt,
        output guess, busy, done, found, result, probe_count
    );

    modport slave (
        output start, cmp_gt, cmp_eq, cmp_lt,
        input  guess, busy, done, found, result, probe_count
    );

endinterface

// File: rtl/comparator_search_controller_midpoint.sv
// Midpoint of the narrowed search window and the empty-window flag.
// Purely combinational, zero latency; no flow control.
// Sum is one bit wider than the operands so lo+hi never overflows.
module search_midpoint #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_hi,
    output logic [WIDTH-1:0] o_mid,
    output logic             o_exhausted
);
    logic [WIDTH:0] w_sum;

    assign w_sum       = {1'b0, i_lo} + {1'b0, i_hi};
    assign o_mid       = WIDTH'(w_sum >> 1);
    assign o_exhausted = (i_lo > i_hi);

endmodule

// File: rtl/comparator_search_controller.sv
// Binary-searches the comparator's fixed operand by driving trial guesses; optional CMP_ONEHOT_CHECK_EN.
// Latency: start -> done = 1 + probes cycles (max WIDTH+1 probes), one probe per cycle.
// No backpressure: start is ignored while busy; done is a single-cycle pulse.
module comparator_search_controller
    import comparator_search_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    comparator_search_controller_if.master bus
);
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH-1:0] MID0 = MAX >> 1;
    localparam logic [0:0] S_IDLE  = 1'(IDLE);
    localparam logic [0:0] S_PROBE = 1'(PROBE);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_guess;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_probe_count;
    logic             r_busy;
    logic             r_done;
    logic             r_found;

    logic             w_flag_err;
    logic             w_take_eq;
    logic             w_take_gt;
    logic             w_take_lt;
    logic             w_at_edge;
    logic             w_exhausted;
    logic             w_stop;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_mid;

`ifdef CMP_ONEHOT_CHECK_EN
    assign w_flag_err = !$onehot({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt});
`else
    assign w_flag_err = 1'b0;
`endif

    // eq wins over gt; anything that is neither (including all-zero) narrows as lt.
    assign w_take_eq = !w_flag_err && bus.cmp_eq;
    assign w_take_gt = !w_flag_err && !bus.cmp_eq && bus.cmp_gt;
    assign w_take_lt = !w_flag_err && !bus.cmp_eq && !bus.cmp_gt;

    // Range edges are caught before lo/hi move, so the +1/-1 below never wraps into use.
    assign w_at_edge = (w_take_gt && (r_guess == MAX)) ||
                       (w_take_lt && (r_guess == '0));
    assign w_lo_nxt  = w_take_gt ? r_guess + WIDTH'(1) : r_lo;
    assign w_hi_nxt  = w_take_lt ? r_guess - WIDTH'(1) : r_hi;

    search_midpoint #(.WIDTH(WIDTH)) u_midpoint (
        .i_lo        (w_lo_nxt),
        .i_hi        (w_hi_nxt),
        .o_mid       (w_mid),
        .o_exhausted (w_exhausted)
    );

    assign w_stop = w_flag_err || w_take_eq || w_at_edge || w_exhausted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_lo          <= '0;
            r_hi          <= '0;
            r_guess       <= '0;
            r_result      <= '0;
            r_probe_count <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_lo          <= '0;
                        r_hi          <= MAX;
                        r_guess       <= MID0;
                        r_probe_count <= '0;
                        r_found       <= 1'b0;
                        r_result      <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    r_probe_count <= r_probe_count + CNT_W'(1);
                    if (w_stop) begin
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_found  <= w_take_eq;
                        r_result <= w_take_eq ? r_guess : '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_lo    <= w_lo_nxt;
                        r_hi    <= w_hi_nxt;
                        r_guess <= w_mid;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.guess       = r_guess;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.found       = r_found;
    assign bus.result      = r_result;
    assign bus.probe_count = r_probe_count;

endmodule

// File: tb/tb_comparator_search_controller.sv
// Bench for comparator_search_controller: behavioural comparator drives the flags from a target value,
// table-driven corner searches, randomized searches against a plain binary-search model, hand sequences.
module tb_comparator_search_controller;
    import comparator_search_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    comparator_search_controller_if #(.WIDTH(8)) bus ();

    comparator_search_controller #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Comparator stand-in: target -1 behaves as "always lt"; force_gt_on_eq makes gt and eq both rise.
    int tgt = 0;
    bit force_gt_on_eq = 1'b0;
    assign bus.cmp_eq = (tgt == int'(bus.guess));
    assign bus.cmp_gt = (tgt > int'(bus.guess)) || (force_gt_on_eq && (tgt == int'(bus.guess)));
    assign bus.cmp_lt = (tgt < int'(bus.guess));

    int errors = 0;
    int checks = 0;

    int obs_q[$];
    int exp_q[$];
    int m_found, m_result;
    int d_cycles, d_found, d_result, d_count, d_busy;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Textbook binary search over 0..255 using unbounded ints.
    function automatic void model(input int t);
        int lo, hi, mid;
        lo = 0; hi = 255; m_found = 0; m_result = 0;
        exp_q.delete();
        while (lo <= hi) begin
            mid = (lo + hi) / 2;
            exp_q.push_back(mid);
            if (t == mid) begin
                m_found = 1; m_result = mid;
                break;
            end else if (t > mid) lo = mid + 1;
            else hi = mid - 1;
        end
    endfunction

    task automatic follow(input bit poke, input bit chain);
        int cycles;
        bit saw;
        cycles = 1; saw = 1'b0;
        obs_q.delete();
        while (!saw && cycles < 40) begin
            @(negedge clk);
            if (bus.done) saw = 1'b1;
            else begin
                if (bus.busy) obs_q.push_back(int'(bus.guess));
                bus.start = poke && (cycles == 3 || cycles == 4);
                @(posedge clk); #1;
                cycles++;
            end
        end
        if (!saw) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done, expected done within 40 cycles");
        end
        d_cycles = cycles;
        d_found  = int'(bus.found);
        d_result = int'(bus.result);
        d_count  = int'(bus.probe_count);
        d_busy   = int'(bus.busy);
        bus.start = chain;
    endtask

    task automatic run_search(input int t, input bit poke, input bit chain);
        tgt = t;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        follow(poke, chain);
    endtask

    task automatic check_against_model(input string tag);
        check({tag, "_nprobes"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_guess%0d", tag, i), obs_q[i], exp_q[i]);
        check({tag, "_found"},  d_found,  m_found);
        check({tag, "_result"}, d_result, m_result);
        check({tag, "_count"},  d_count,  exp_q.size());
        check({tag, "_cycles"}, d_cycles, exp_q.size() + 1);
    endtask

    typedef struct {
        int target;
        int exp_found;
        int exp_result;
        int exp_count;
        int exp_cycles;
        int exp_first;
        int exp_last;
    } vec_t;

    vec_t tbl[4];
    int seq100[8];
    int dones;

    initial begin
        tbl[0] = '{100, 1, 100, 8, 9, 127, 100};
        tbl[1] = '{255, 1, 255, 9, 10, 127, 255};
        tbl[2] = '{0,   1, 0,   8, 9, 127, 0};
        tbl[3] = '{-1,  0, 0,   8, 9, 127, 0};
        seq100 = '{127, 63, 95, 111, 103, 99, 101, 100};

        rst_n = 1'b0;
        bus.start = 1'b0;
        #12;
        check("rst_guess", int'(bus.guess), 0);
        check("rst_busy",  int'(bus.busy), 0);
        check("rst_done",  int'(bus.done), 0);
        check("rst_found", int'(bus.found), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_count", int'(bus.probe_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            string tag;
            tag = $sformatf("tbl%0d", v);
            run_search(tbl[v].target, 1'b0, 1'b0);
            check({tag, "_found"},  d_found,  tbl[v].exp_found);
            check({tag, "_result"}, d_result, tbl[v].exp_result);
            check({tag, "_count"},  d_count,  tbl[v].exp_count);
            check({tag, "_cycles"}, d_cycles, tbl[v].exp_cycles);
            check({tag, "_busy_at_done"}, d_busy, 0);
            check({tag, "_first"}, (obs_q.size() > 0) ? obs_q[0] : -99, tbl[v].exp_first);
            check({tag, "_last"},  (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : -99, tbl[v].exp_last);
            @(negedge clk);
            check({tag, "_done_1cycle"}, int'(bus.done), 0);
            check({tag, "_result_held"}, int'(bus.result), tbl[v].exp_result);
            if (v == 0)
                for (int i = 0; i < 8; i++)
                    check($sformatf("seq100_%0d", i), (i < obs_q.size()) ? obs_q[i] : -99, seq100[i]);
        end

        // Randomized targets, some with start pulses while busy.
        for (int n = 0; n < 16; n++) begin
            int t;
            bit poke;
            t = int'($urandom_range(0, 255));
            poke = 1'($urandom_range(0, 1));
            model(t);
            run_search(t, poke, 1'b0);
            check_against_model($sformatf("rnd%0d_t%0d", n, t));
            @(negedge clk);
            check("rnd_done_1cycle", int'(bus.done), 0);
        end

        // Start held in the done cycle launches the next search immediately.
        run_search(100, 1'b0, 1'b1);
        check("chain_first_found", d_found, 1);
        tgt = 200;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("chain_busy", int'(bus.busy), 1);
        check("chain_guess", int'(bus.guess), 127);
        check("chain_count_clr", int'(bus.probe_count), 0);
        check("chain_found_clr", int'(bus.found), 0);
        check("chain_result_clr", int'(bus.result), 0);
        follow(1'b0, 1'b0);
        model(200);
        check_against_model("chain2");
        @(negedge clk);

        // Reset asserted during probe 4 abandons the search with no done.
        tgt = 100;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_guess_probe4", int'(bus.guess), 111);
        rst_n = 1'b0;
        #1;
        check("arst_guess", int'(bus.guess), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_done", int'(bus.done), 0);
        check("arst_count", int'(bus.probe_count), 0);
        check("arst_found", int'(bus.found), 0);
        check("arst_result", int'(bus.result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("arst_no_done_after", dones, 0);
        model(100);
        run_search(100, 1'b1, 1'b0);
        check_against_model("post_rst");
        @(negedge clk);

        // gt and eq both high on probe 2.
        force_gt_on_eq = 1'b1;
        run_search(63, 1'b0, 1'b0);
        check("dual_count", d_count, 2);
        check("dual_cycles", d_cycles, 3);
`ifdef CMP_ONEHOT_CHECK_EN
        check("dual_found", d_found, 0);
        check("dual_result", d_result, 0);
`else
        check("dual_found", d_found, 1);
        check("dual_result", d_result, 63);
`endif
        force_gt_on_eq = 1'b0;
        @(negedge clk);
        check("dual_done_1cycle", int'(bus.done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
